// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests one word at the PC, waits for the
// response, presents it to decode and holds it until consumed; redirects replace the PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRValid,
    input  logic [31:0] imemRData,
    output logic [31:0] instrCode,
    output logic [31:0] instrPC,
    output logic        instrValid,
    input  logic        instrReady,
    input  logic        redirect,
    input  logic [31:0] redirectPC
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] code_reg, code_next;
    logic [31:0] ipc_reg, ipc_next;
    logic        valid_reg, valid_next;

    logic [31:0] redirect_aligned;
    logic        capture;
    logic        redirect_low_unused;

    assign redirect_aligned    = {redirectPC[31:2], 2'b00};
    assign redirect_low_unused = ^redirectPC[1:0];

    // A response is only accepted into the decode registers when no redirect kills it.
    assign capture = (state_reg == WAIT) && imemRValid && !redirect;

    // State register (and the datapath registers that move with it)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            code_reg  <= NOP;
            ipc_reg   <= 32'h0000_0000;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            code_reg  <= code_next;
            ipc_reg   <= ipc_next;
            valid_reg <= valid_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect)
                    state_next = imemReady ? DROP : REQ;
                else if (imemReady)
                    state_next = WAIT;
            end
            WAIT: begin
                if (redirect)
                    state_next = imemRValid ? REQ : DROP;
                else if (imemRValid)
                    state_next = HOLD;
            end
            // A redirect here only moves the PC; once the stale response has been
            // swallowed nothing is outstanding, so leaving DROP cannot deadlock.
            DROP: begin
                if (imemRValid)
                    state_next = REQ;
            end
            HOLD: begin
                if (redirect || instrReady)
                    state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        pc_next    = pc_reg;
        code_next  = code_reg;
        ipc_next   = ipc_reg;
        valid_next = valid_reg;
        if (redirect)
            pc_next = redirect_aligned;
        else if (capture)
            pc_next = pc_reg + 32'd4;
        if (capture) begin
            code_next  = imemRData;
            ipc_next   = pc_reg;
            valid_next = 1'b1;
        end else if ((state_reg == HOLD) && (redirect || instrReady)) begin
            valid_next = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        imemReq    = (state_reg == REQ);
        imemAddr   = pc_reg;
        instrCode  = code_reg;
        instrPC    = ipc_reg;
        instrValid = valid_reg;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imemReq  output  1  instruction-memory request strobe.
REQ-005 imemAddr  output  32  fetch address, always equal to current PC.
REQ-006 imemReady  input  1  memory accepts request when imemReq & imemReady.
REQ-007 imemRValid  input  1  one-cycle response strobe, at least 1 cycle after acceptance.
REQ-008 imemRData  input  32  response instruction word, valid with imemRValid.
REQ-009 instrCode  output  32  registered instruction word presented to the decode stage.
REQ-010 instrPC  output  32  address of instrCode.
REQ-011 instrValid  output  1  instrCode/instrPC valid for decode.
REQ-012 instrReady  input  1  decode consumes instruction when instrValid & instrReady.
REQ-013 redirect  input  1  branch/jump taken; PC SHALL be replaced by redirectPC.
REQ-014 redirectPC  input  32  redirect target; bits [1:0] ignored and forced to 0.

Function
REQ-015 The block SHALL implement FSM states IDLE, REQ, WAIT, DROP, HOLD, with at most one memory request outstanding.
REQ-016 IDLE: imemReq=0; unconditional move to REQ next cycle (redirect in IDLE updates PC, still to REQ).
REQ-017 REQ: imemReq=1; on imemReady, move to WAIT; otherwise stay in REQ with imemAddr stable.
REQ-018 WAIT: imemReq=0; on imemRValid, instrCode<=imemRData, instrPC<=PC, PC<=PC+4, instrValid<=1, move to HOLD.
REQ-019 HOLD: instrValid=1, instrCode/instrPC stable; on instrReady, instrValid<=0 and move to REQ.
REQ-020 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 Redirect SHALL have priority over every event except reset; PC<={redirectPC[31:2],2'b00} in the same edge.
REQ-022 Redirect in REQ without acceptance: move to REQ with new address next cycle; redirect in REQ with acceptance same cycle: move to DROP.
REQ-023 Redirect in WAIT without imemRValid: move to DROP; redirect with imemRValid same cycle: response discarded, move to REQ.
REQ-024 DROP: imemReq=0; next imemRValid SHALL be discarded (no output change), then move to REQ; redirect in DROP updates PC, stays in DROP.
REQ-025 Redirect in HOLD (with or without instrReady): instrValid<=0, move to REQ; held instruction SHALL not be re-presented.
REQ-026 imemRValid in IDLE, REQ or HOLD SHALL be ignored.
REQ-027 Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with zero-wait memory and instrReady=1).

Reset
REQ-028 On reset: state=IDLE, PC=RESET_PC, imemReq=0, instrValid=0, instrCode=32'h0000_0013 (NOP), instrPC=32'h0.
REQ-029 Reset mid-operation SHALL abandon any outstanding request; a late imemRValid after reset SHALL be ignored per REQ-026.
REQ-030 Reset SHALL override simultaneous redirect, imemRValid and instrReady.

Verification
REQ-031 Reset, imemReady=1, 1-cycle memory returning 32'h0050_0093, instrReady=1 -> imemAddr 0,4,8; instrValid pulses every 3rd cycle; first instrCode=32'h0050_0093, instrPC=0.
REQ-032 instrReady=0 for 5 cycles in HOLD -> instrValid, instrCode, instrPC stable; no imemReq; fetch of PC+4 starts the cycle after instrReady=1.
REQ-033 Redirect to 32'h0000_0103 during WAIT, response arrives 2 cycles later -> response dropped, instrValid stays 0, next imemAddr=32'h0000_0100.
REQ-034 Redirect and imemRValid same cycle in WAIT -> data discarded, next cycle imemReq=1, imemAddr=redirectPC.
REQ-035 RESET_PC=32'hFFFF_FFFC, one fetch completed -> instrPC=32'hFFFF_FFFC, next imemAddr=32'h0000_0000.
REQ-036 imemReady=0 for 4 cycles in REQ, then reset asserted -> imemReq=0 next cycle, outputs at reset values, stray imemRValid ignored.
